// File: rtl/matmul_host_seq_if.sv
// Byte-stream, controller load/read and status signals of the matmul host sequencer.
// slave = the sequencer itself, master = the surrounding host/controller side.
interface matmul_host_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;
  logic       ctl_rst;
  logic       load_en;
  logic       load_sel_ab;
  logic [1:0] load_index;
  logic [7:0] load_data;
  logic       output_en;
  logic [1:0] output_sel;
  logic [7:0] out_data;

  modport slave (
    input  in_valid, in_data, res_ready, out_data,
    output in_ready, res_valid, res_data, busy, ctl_rst,
           load_en, load_sel_ab, load_index, load_data, output_en, output_sel
  );

  modport master (
    output in_valid, in_data, res_ready, out_data,
    input  in_ready, res_valid, res_data, busy, ctl_rst,
           load_en, load_sel_ab, load_index, load_data, output_en, output_sel
  );
endinterface

// File: rtl/matmul_host_seq.sv
// Host-side sequencer for the 2x2 matmul controller: load 8 bytes, wait, burst-read 4, stream back.
// Optional MATMUL_SEQ_PERF_EN adds a 16-bit completed-job counter port.
//
// state | meaning
// CLR   | controller reset pulse, byte counter cleared
// IDLE  | ready for first job byte
// LOAD  | forwarding job bytes 1..7 to the controller load port
// WAIT  | fixed delay until the controller reaches its output state
// READ  | 4-cycle output_en burst, results captured into rbuf
// SEND  | streaming rbuf[0..3] over the result handshake
module matmul_host_seq #(
  parameter int READ_DELAY = 6
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MATMUL_SEQ_PERF_EN
  output logic [15:0]       job_count,
`endif
  matmul_host_seq_if.slave  bus
);

  typedef enum logic [2:0] {S_CLR, S_IDLE, S_LOAD, S_WAIT, S_READ, S_SEND} state_t;

  localparam logic [3:0] DLY_INIT = 4'(READ_DELAY - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] dly_q, dly_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] rbuf_q [4];
  logic [7:0] rbuf_d [4];
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;
  logic       ctl_rst_q, ctl_rst_d;
  logic       load_en_q, load_en_d;
  logic       load_sel_q, load_sel_d;
  logic [1:0] load_idx_q, load_idx_d;
  logic [7:0] load_data_q, load_data_d;
  logic       oe_q, oe_d;
  logic [1:0] osel_q, osel_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_data_q, res_data_d;
`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0] job_q, job_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dly_d       = dly_q;
    idx_d       = idx_q;
    rbuf_d      = rbuf_q;
    load_en_d   = 1'b0;
    load_sel_d  = load_sel_q;
    load_idx_d  = load_idx_q;
    load_data_d = load_data_q;
    oe_d        = 1'b0;
    osel_d      = osel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
`ifdef MATMUL_SEQ_PERF_EN
    job_d       = job_q;
`endif
    case (state_q)
      S_CLR: begin
        cnt_d   = 3'd0;
        state_d = S_IDLE;
      end
      S_IDLE, S_LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          load_en_d   = 1'b1;
          load_sel_d  = cnt_q[2];
          load_idx_d  = cnt_q[1:0];
          load_data_d = bus.in_data;
          cnt_d       = cnt_q + 3'd1;
          dly_d       = DLY_INIT;
          state_d     = (cnt_q == 3'd7) ? S_WAIT : S_LOAD;
        end
      end
      S_WAIT: begin
        if (dly_q == 4'd0) begin
          state_d = S_READ;
          oe_d    = 1'b1;
          osel_d  = 2'd0;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      S_READ: begin
        // The controller drops out of its output state after 4 enables, so never stall here.
        rbuf_d[osel_q] = bus.out_data;
        if (osel_q == 2'd3) begin
          state_d     = S_SEND;
          osel_d      = 2'd0;
          idx_d       = 2'd0;
          res_valid_d = 1'b1;
          res_data_d  = rbuf_q[0];
        end else begin
          oe_d   = 1'b1;
          osel_d = osel_q + 2'd1;
        end
      end
      S_SEND: begin
        if (res_valid_q && bus.res_ready) begin
          if (idx_q == 2'd3) begin
            state_d     = S_CLR;
            res_valid_d = 1'b0;
            cnt_d       = 3'd0;
`ifdef MATMUL_SEQ_PERF_EN
            job_d       = job_q + 16'd1;
`endif
          end else begin
            idx_d      = idx_q + 2'd1;
            res_data_d = rbuf_q[idx_q + 2'd1];
          end
        end
      end
      default: state_d = S_CLR;
    endcase
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
    ctl_rst_d  = (state_d == S_CLR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLR;
      cnt_q       <= 3'd0;
      dly_q       <= 4'd0;
      idx_q       <= 2'd0;
      rbuf_q      <= '{default: 8'h00};
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      ctl_rst_q   <= 1'b1;
      load_en_q   <= 1'b0;
      load_sel_q  <= 1'b0;
      load_idx_q  <= 2'd0;
      load_data_q <= 8'h00;
      oe_q        <= 1'b0;
      osel_q      <= 2'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
`ifdef MATMUL_SEQ_PERF_EN
      job_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
      rbuf_q      <= rbuf_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      ctl_rst_q   <= ctl_rst_d;
      load_en_q   <= load_en_d;
      load_sel_q  <= load_sel_d;
      load_idx_q  <= load_idx_d;
      load_data_q <= load_data_d;
      oe_q        <= oe_d;
      osel_q      <= osel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
`ifdef MATMUL_SEQ_PERF_EN
      job_q       <= job_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.ctl_rst     = ctl_rst_q;
  assign bus.load_en     = load_en_q;
  assign bus.load_sel_ab = load_sel_q;
  assign bus.load_index  = load_idx_q;
  assign bus.load_data   = load_data_q;
  assign bus.output_en   = oe_q;
  assign bus.output_sel  = osel_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
`ifdef MATMUL_SEQ_PERF_EN
  assign job_count       = job_q;
`endif

endmodule
